nibble_serial_adder_ctrl: RTL
=============================

# nibble_serial_adder_ctrl

Multi-cycle sequencer that adds (or subtracts) two WIDTH-bit operands by time-sharing one instance of the team's 4-bit carry-lookahead slice (CLA4), one nibble per cycle, least significant nibble first, with a registered carry between nibbles. It sits in the floating-point multiplier datapath wherever a wide add is needed but area matters more than latency, such as exponent add/bias subtract and mantissa rounding increment. Operands enter and results leave through ready/valid handshakes.

## Interface
- WIDTH, default 24: operand width in bits. Must be a multiple of 4 and at least 4.
- NIB, fixed at WIDTH/4: number of nibble steps (a localparam, not overridable).
- clk  in  1: clock. All state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: operands a, b, cin and sub are valid.
- in_ready  out  1: block can accept an operation. High only in IDLE.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B.
- cin  in  1: carry-in for add. Ignored when sub=1.
- sub  in  1: 0 computes A+B+cin; 1 computes A+~B+1 (that is, A−B).
- out_valid  out  1: sum is valid. High only in DONE.
- out_ready  in  1: consumer accepts sum.
- sum  out  WIDTH+1: result. Bit WIDTH is the final carry. For sub, 1 means no borrow (A≥B unsigned).
- busy  out  1: high in RUN or DONE.

## Operation
- There are three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - in_ready=1.
  - On in_valid, the block:
    - latches a into opA;
    - latches (sub ? ~b : b) into opB;
    - sets carry_reg to (sub ? 1 : cin);
    - clears idx to 0 and clears the result register;
    - moves to RUN.
- **RUN:**
  - The CLA4 slice receives opA[4*idx+3:4*idx], opB[4*idx+3:4*idx] and Ci=carry_reg.
  - Each cycle, the slice's sum[3:0] is written into result[4*idx+3:4*idx], and the slice's sum[4] is written into carry_reg.
  - When idx<NIB−1: idx increments.
  - When idx=NIB−1: result[WIDTH] takes the slice's sum[4], and the state moves to DONE.
- **DONE:**
  - out_valid=1.
  - sum and busy are held stable.
  - On out_ready, the state moves to IDLE.
- **Handshakes:**
  - No new operation is accepted in DONE, even if out_ready and in_valid are both high in the same cycle. in_ready is a pure decode of state==IDLE.
  - Inputs a, b, cin and sub are sampled only on the accept edge. Later changes have no effect.
  - in_ready and out_valid never depend combinationally on in_valid or out_ready.
- **Outputs:**
  - sum is driven from the result register. It is 0 after reset and retains the last result in IDLE until the next accept clears it.
- **Arithmetic:**
  - The result is exact modulo 2^(WIDTH+1).
  - No overflow or sign flag is produced. Signed interpretation is the consumer's job.
- **Reset mid-operation:**
  - rst in any state returns the block to IDLE on that edge and clears idx, carry_reg and result.
  - out_valid=0, busy=0 and in_ready=1 from the next cycle.
  - A partially computed result is discarded and is never presented.
- **Reset priority:** rst has priority over every handshake in the same cycle.

## Timing
- **Reset values:**
  - in_ready=1, out_valid=0, busy=0, sum=0.
  - Internally: idx=0, carry_reg=0.
- **Latency:** if the accept edge is E0, nibble k is processed in the cycle after edge Ek. out_valid rises after edge E_NIB, so it is first seen high NIB cycles after the accept edge (6 cycles at WIDTH=24).
- **Throughput:** at most one operation per NIB+2 cycles, counting the accept cycle, NIB RUN cycles and at least one DONE cycle, with out_ready held high.
- **Back-pressure:** DONE lasts for as long as out_ready stays low, with no limit. sum is unchanged during the stall.
- **Carry path:** the carry chain is exactly one CLA4 slice plus the carry_reg flop per cycle. There is no combinational path from a or b to sum.

## Test plan
- **Basic add, WIDTH=8:** a=0x3C, b=0x5A, cin=0, sub=0 → out_valid 2 cycles after accept, sum=0x096.
- **Carry ripple across all nibbles, WIDTH=24:** a=0xFFFFFF, b=0x000000, cin=1 → sum=0x1000000 after 6 cycles, with carry propagating through every step.
- **Subtract, WIDTH=8:**
  - a=0x10, b=0x01, sub=1, cin=1 (must be ignored) → sum=0x10F (carry=1, no borrow).
  - a=0x01, b=0x10 → sum=0x0F1 (borrow).
- **Back-pressure:** hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, sum stays stable and in_ready stays 0. Also drive in_valid=1 with new operands throughout → they are not accepted until the cycle after the out_ready handshake returns to IDLE.
- **Reset mid-RUN, WIDTH=24:** assert rst at nibble index 3 → next cycle shows IDLE with sum=0, out_valid=0, busy=0, in_ready=1. A following add of 0x000001+0x000001 → sum=0x0000002.
- **Input change after accept:** change a and b every cycle during RUN → the result matches the operands sampled at the accept edge. Run a random sweep of 1000 operations at WIDTH=24 against a reference-model add/subtract.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice is reused
// once per nibble, LSB nibble first, with the inter-nibble carry held in a flop.

module nsa_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [4:0] s
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = {c[4], p ^ c[3:0]};
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH:0]   result_q, result_d;

    logic [IDX_W+1:0] nib_lo;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [4:0]       slice_sum;

    // Handshake flags decode state only, so they never see in_valid/out_ready.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = result_q;

    assign nib_lo  = {idx_q, 2'b00};
    assign slice_a = opa_q[nib_lo +: 4];
    assign slice_b = opb_q[nib_lo +: 4];

    nsa_cla4 u_cla4 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_sum)
    );

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1; the +1 rides in on the carry.
                    opa_d    = a;
                    opb_d    = sub ? ~b : b;
                    carry_d  = sub ? 1'b1 : cin;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[nib_lo +: 4] = slice_sum[3:0];
                carry_d               = slice_sum[4];
                if (idx_q == LAST_IDX) begin
                    result_d[WIDTH] = slice_sum[4];
                    state_d         = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end
endmodule
